mem_responder: RTL and testbench

//  Memory-side responder for the CPU's two memory ports: the instruction port
//  (readM1/address1/data1) and the data port (readM2/writeM2/address2/data2).

---
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency backing store serving an instruction read port
// and a data read/write port from one shared word array, one access at a time.
module mem_responder #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  inout  wire  [WORD_SIZE-1:0] data1,
  output logic                 complete1,
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic                 complete2,
  output logic                 busy
);

  localparam int unsigned ADDR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 port_q;   // 1 = data port, 0 = instruction port
  logic                 write_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;

  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  logic                 d_req;
  logic                 served_req;
  logic [WORD_SIZE-1:0] served_addr;
  logic                 withdraw;
  logic                 is_busy;
  logic                 accept;
  logic                 accept_d;
  logic                 mem_we;
  logic                 mem_re;
  logic                 complete1_d;
  logic                 complete2_d;
  logic                 busy_d;
  logic [ADDR_W-1:0]    mem_idx;

  // Request decode and withdrawal detection for the access in flight.
  always_comb begin
    d_req       = readM2 | writeM2;
    served_req  = port_q ? d_req : readM1;
    served_addr = port_q ? address2 : address1;
    withdraw    = !served_req || (served_addr != addr_q);
    is_busy     = (state_q == I_BUSY) || (state_q == D_BUSY);
    mem_idx     = addr_q[ADDR_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; the edge leaving DONE also acts as the IDLE acceptance edge,
  // so a request held through DONE starts its new access on that edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (d_req)       state_d = D_BUSY;
        else if (readM1) state_d = I_BUSY;
        else             state_d = IDLE;
      end
      I_BUSY, D_BUSY: begin
        if (withdraw)           state_d = IDLE;
        else if (cnt_q == '0)   state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs: acceptance, array strobes and next values of the flags.
  always_comb begin
    accept      = 1'b0;
    accept_d    = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    complete1_d = 1'b0;
    complete2_d = 1'b0;
    busy_d      = (state_d == I_BUSY) || (state_d == D_BUSY);
    if (((state_q == IDLE) || (state_q == DONE)) && (d_req || readM1)) begin
      accept   = 1'b1;
      accept_d = d_req;
    end
    if (is_busy && !withdraw && (cnt_q == '0)) begin
      mem_we      = write_q;
      mem_re      = !write_q;
      complete1_d = !port_q;
      complete2_d = port_q;
    end
  end

  // Registered flags, access latch and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      complete1 <= 1'b0;
      complete2 <= 1'b0;
      busy      <= 1'b0;
      cnt_q     <= '0;
      port_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      complete1 <= complete1_d;
      complete2 <= complete2_d;
      busy      <= busy_d;
      if (accept) begin
        port_q  <= accept_d;
        write_q <= accept_d & writeM2;
        addr_q  <= accept_d ? address2 : address1;
        wdata_q <= data2;
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if (is_busy && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Array port: write commits and read data is captured on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wdata_q;
    if (mem_re) rdata_q <= mem[mem_idx];
  end

  // Buses are driven only during the completing cycle of a read, and only
  // while the owning port still holds its read request.
  assign data1 = (complete1 && readM1) ? rdata_q : {WORD_SIZE{1'bz}};
  assign data2 = (complete2 && !write_q && readM2 && !writeM2) ? rdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random accesses on both ports of
// mem_responder, checked against an associative-array memory model and the
// fixed request-to-complete latency.
module tb_mem_responder;

  localparam int unsigned W     = 16;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         readM1;
  logic         readM2;
  logic         writeM2;
  logic [W-1:0] address1;
  logic [W-1:0] address2;
  wire  [W-1:0] data1;
  wire  [W-1:0] data2;
  logic         complete1;
  logic         complete2;
  logic         busy;
  logic         d2_drv;
  logic [W-1:0] d2_val;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] model_mem [int unsigned];

  assign data2 = d2_drv ? d2_val : {W{1'bz}};

  always #5 clk = ~clk;

  mem_responder #(
    .WORD_SIZE(W),
    .MEM_WORDS(DEPTH),
    .LATENCY  (LAT),
    .INIT_FILE("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .readM1   (readM1),
    .address1 (address1),
    .data1    (data1),
    .complete1(complete1),
    .readM2   (readM2),
    .writeM2  (writeM2),
    .address2 (address2),
    .data2    (data2),
    .complete2(complete2),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request at a negedge (DUT idle or in its completing cycle) and
  // expects the complete pulse exactly LAT+1 negedges later.
  task automatic do_access(input bit dport, input bit wr, input logic [W-1:0] addr,
                           input logic [W-1:0] wd, input string tag);
    int unsigned idx;
    idx = addr % DEPTH;
    if (dport) begin
      writeM2  = wr;
      readM2   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      address2 = addr;
      d2_drv   = wr;
      d2_val   = wd;
    end else begin
      readM2   = 1'b0;
      writeM2  = 1'b0;
      d2_drv   = 1'b0;
      readM1   = 1'b1;
      address1 = addr;
    end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check({tag, " early complete"}, W'(complete1 | complete2), '0);
      check({tag, " busy"}, W'(busy), W'(1));
    end
    @(negedge clk);
    check({tag, " complete1"}, W'(complete1), W'(!dport));
    check({tag, " complete2"}, W'(complete2), W'(dport));
    check({tag, " busy at done"}, W'(busy), '0);
    if (wr) begin
      model_mem[idx] = wd;
    end else if (model_mem.exists(idx)) begin
      check({tag, " rdata"}, dport ? data2 : data1, model_mem[idx]);
    end
  endtask

  task automatic release_all();
    readM1  = 1'b0;
    readM2  = 1'b0;
    writeM2 = 1'b0;
    d2_drv  = 1'b0;
    @(negedge clk);
    check("idle complete1", W'(complete1), '0);
    check("idle complete2", W'(complete2), '0);
    check("idle busy", W'(busy), '0);
  endtask

  initial begin
    bit           dp;
    bit           wr;
    logic [W-1:0] a;

    reset    = 1'b1;
    readM1   = 1'b0;
    readM2   = 1'b0;
    writeM2  = 1'b0;
    address1 = '0;
    address2 = '0;
    d2_drv   = 1'b0;
    d2_val   = '0;
    repeat (2) @(negedge clk);
    check("reset complete1", W'(complete1), '0);
    check("reset complete2", W'(complete2), '0);
    check("reset busy", W'(busy), '0);
    reset = 1'b0;
    @(negedge clk);

    // Instruction read of a preloaded word.
    do_access(1'b1, 1'b1, 16'h0010, 16'hBEEF, "t1 preload");
    release_all();
    do_access(1'b0, 1'b0, 16'h0010, '0, "t1 ifetch");
    check("t1 data1 value", data1, 16'hBEEF);
    release_all();

    // Write then read back on the data port.
    do_access(1'b1, 1'b1, 16'h0020, 16'h1234, "t2 write");
    release_all();
    do_access(1'b1, 1'b0, 16'h0020, '0, "t2 read");
    check("t2 data2 value", data2, 16'h1234);
    release_all();

    // Simultaneous requests: data port first, instruction port right after.
    readM1   = 1'b1;
    address1 = 16'h0010;
    do_access(1'b1, 1'b0, 16'h0020, '0, "t3 data first");
    do_access(1'b0, 1'b0, 16'h0010, '0, "t3 instr second");
    release_all();

    // Reset two cycles into a write aborts it and leaves the word intact.
    do_access(1'b1, 1'b1, 16'h0030, 16'h5555, "t4 preload");
    release_all();
    writeM2  = 1'b1;
    readM2   = 1'b0;
    address2 = 16'h0030;
    d2_drv   = 1'b1;
    d2_val   = 16'hAAAA;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t4 busy in reset", W'(busy), '0);
    check("t4 complete2 in reset", W'(complete2), '0);
    @(negedge clk);
    writeM2 = 1'b0;
    d2_drv  = 1'b0;
    reset   = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("t4 no complete2", W'(complete2), '0);
    end
    do_access(1'b1, 1'b0, 16'h0030, '0, "t4 readback");
    check("t4 old word kept", data2, 16'h5555);
    release_all();

    // Address wrap aliases word 0.
    do_access(1'b1, 1'b1, 16'h0400, 16'hC0DE, "t5 alias write");
    release_all();
    do_access(1'b1, 1'b0, 16'h0000, '0, "t5 alias read");
    check("t5 alias value", data2, 16'hC0DE);
    release_all();

    // Request withdrawn mid-access: no pulse, back to idle.
    readM2   = 1'b1;
    address2 = 16'h0005;
    repeat (2) @(negedge clk);
    readM2 = 1'b0;
    @(negedge clk);
    check("t5 withdraw busy", W'(busy), '0);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("t5 withdraw no complete2", W'(complete2), '0);
    end

    // Address change mid-access also aborts.
    readM1   = 1'b1;
    address1 = 16'h0003;
    repeat (2) @(negedge clk);
    address1 = 16'h0004;
    @(negedge clk);
    check("t5 addr change busy", W'(busy), '0);
    readM1 = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("t5 addr change no complete1", W'(complete1), '0);
    end

    // Back-to-back writes then back-to-back instruction reads over 0..7.
    for (int i = 0; i < 8; i++) begin
      do_access(1'b1, 1'b1, W'(i), W'($urandom), "t6 fill");
    end
    for (int i = 0; i < 8; i++) begin
      do_access(1'b0, 1'b0, W'(i), '0, "t6 burst");
    end
    release_all();

    // Random traffic over aliased addresses of words 0..7.
    for (int i = 0; i < 60; i++) begin
      dp = 1'($urandom_range(0, 1));
      wr = dp && ($urandom_range(0, 2) == 0);
      a  = W'(($urandom & 32'h0000_FC00) | $urandom_range(0, 7));
      if (dp) readM1 = 1'b0;
      do_access(dp, wr, a, W'($urandom), "rand");
      if ($urandom_range(0, 1) == 1) release_all();
    end
    release_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
